// File: rtl/baud_tick_sched_if.sv
// Host/UART-side signal bundle for the baud tick scheduler: rate requests,
// busy/sync status from the UART, and the tick/status outputs.
interface baud_tick_sched_if;
   logic [1:0] cfg_div;
   logic       cfg_wr;
   logic       tx_busy;
   logic       rx_busy;
   logic       rx_sync;
   logic       tx_tick;
   logic       rx_tick;
   logic [1:0] div_active;
   logic       cfg_pending;

   modport slave (
      input  cfg_div,
      input  cfg_wr,
      input  tx_busy,
      input  rx_busy,
      input  rx_sync,
      output tx_tick,
      output rx_tick,
      output div_active,
      output cfg_pending
   );

   modport master (
      output cfg_div,
      output cfg_wr,
      output tx_busy,
      output rx_busy,
      output rx_sync,
      input  tx_tick,
      input  rx_tick,
      input  div_active,
      input  cfg_pending
   );
endinterface

// File: rtl/baud_tick_sched.sv
// Shared UART baud scheduler: TX bit tick plus a start-bit-aligned RX sample
// tick, with rate changes deferred until both directions are idle.
module baud_tick_sched #(
   parameter int unsigned SCALE     = 28,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic              clock,
   input  logic              reset,
   baud_tick_sched_if.slave  bus
);

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } cfgState_e;

   localparam logic [CNT_WIDTH-1:0] PERIOD_X1 = CNT_WIDTH'(SCALE);
   localparam logic [CNT_WIDTH-1:0] PERIOD_X2 = CNT_WIDTH'(2 * SCALE);
   localparam logic [CNT_WIDTH-1:0] PERIOD_X3 = CNT_WIDTH'(3 * SCALE);
   localparam logic [CNT_WIDTH-1:0] PERIOD_X6 = CNT_WIDTH'(6 * SCALE);

   cfgState_e            state_q, state_d;
   logic [1:0]           pendingDiv_q, pendingDiv_d;
   logic [1:0]           divActive_q, divActive_d;
   logic [CNT_WIDTH-1:0] txCnt_q, txCnt_d;
   logic [CNT_WIDTH-1:0] rxCnt_q, rxCnt_d;
   logic                 txTick_q, txTick_d;
   logic                 rxTick_q, rxTick_d;
   logic                 applyNow;

   logic [CNT_WIDTH-1:0] period;
   logic [CNT_WIDTH-1:0] lastCount;
   logic [CNT_WIDTH-1:0] syncLoad;

   always_comb begin
      period = PERIOD_X1;
      case (divActive_q)
         2'd0:    period = PERIOD_X1;
         2'd1:    period = PERIOD_X2;
         2'd2:    period = PERIOD_X3;
         default: period = PERIOD_X6;
      endcase
   end

   // Loading P-H on a sync puts the next wrap, and thus the sample tick, H cycles out.
   assign lastCount = period - CNT_WIDTH'(1);
   assign syncLoad  = period - (period >> 1);

   // A write always wins over an apply in the same cycle so the newest request is never skipped.
   always_comb begin
      state_d      = state_q;
      pendingDiv_d = pendingDiv_q;
      divActive_d  = divActive_q;
      applyNow     = 1'b0;
      if (bus.cfg_wr) begin
         pendingDiv_d = bus.cfg_div;
         state_d      = PEND;
      end else if (state_q == PEND && !bus.tx_busy && !bus.rx_busy) begin
         applyNow    = 1'b1;
         divActive_d = pendingDiv_q;
         state_d     = IDLE;
      end
   end

   always_comb begin
      txCnt_d  = txCnt_q + CNT_WIDTH'(1);
      txTick_d = 1'b0;
      rxCnt_d  = rxCnt_q + CNT_WIDTH'(1);
      rxTick_d = 1'b0;
      if (applyNow) begin
         txCnt_d = '0;
         rxCnt_d = '0;
      end else begin
         if (txCnt_q == lastCount) begin
            txCnt_d  = '0;
            txTick_d = 1'b1;
         end
         if (bus.rx_sync) begin
            rxCnt_d = syncLoad;
         end else if (rxCnt_q == lastCount) begin
            rxCnt_d  = '0;
            rxTick_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         pendingDiv_q <= 2'd0;
         divActive_q  <= 2'd0;
         txCnt_q      <= '0;
         rxCnt_q      <= '0;
         txTick_q     <= 1'b0;
         rxTick_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         pendingDiv_q <= pendingDiv_d;
         divActive_q  <= divActive_d;
         txCnt_q      <= txCnt_d;
         rxCnt_q      <= rxCnt_d;
         txTick_q     <= txTick_d;
         rxTick_q     <= rxTick_d;
      end
   end

   assign bus.tx_tick     = txTick_q;
   assign bus.rx_tick     = rxTick_q;
   assign bus.div_active  = divActive_q;
   assign bus.cfg_pending = (state_q == PEND);

endmodule

// File: tb/tb_baud_tick_sched.sv
// Randomized bench for baud_tick_sched against an event-schedule model that
// tracks the absolute edge of the next expected TX/RX tick.
module tb_baud_tick_sched;

   localparam int unsigned SCALE     = 4;
   localparam int unsigned CNT_WIDTH = 16;

   logic clock;
   logic reset;

   baud_tick_sched_if bus ();

   baud_tick_sched #(
      .SCALE     (SCALE),
      .CNT_WIDTH (CNT_WIDTH)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int checkCount = 0;
   int failCount  = 0;

   longint edgeNum   = 0;
   longint nextTx    = 0;
   longint nextRx    = 0;
   int     modelDiv  = 0;
   int     modelPDiv = 0;
   bit     modelPend = 0;
   bit     expTx     = 0;
   bit     expRx     = 0;
   bit     txBusyState = 0;
   bit     rxBusyState = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic longint periodOf(input int d);
      case (d)
         0:       return longint'(SCALE);
         1:       return longint'(2 * SCALE);
         2:       return longint'(3 * SCALE);
         default: return longint'(6 * SCALE);
      endcase
   endfunction

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed != expected) begin
         failCount++;
         $display("[TB] FAIL %s at edge %0d: got %0d expected %0d", tag, edgeNum, observed, expected);
      end
   endtask

   // Reference: each tick is scheduled as an absolute edge number; applies and
   // syncs just reschedule, the rest is bookkeeping of the config request.
   task automatic modelStep(input bit rst, input bit wr, input int dv,
                            input bit txb, input bit rxb, input bit sync);
      bit     doApply;
      longint p;
      if (rst) begin
         modelDiv  = 0;
         modelPDiv = 0;
         modelPend = 0;
         expTx     = 0;
         expRx     = 0;
         nextTx    = edgeNum + periodOf(0);
         nextRx    = edgeNum + periodOf(0);
         return;
      end
      doApply = !wr && modelPend && !txb && !rxb;
      if (wr) begin
         modelPend = 1;
         modelPDiv = dv;
      end else if (doApply) begin
         modelDiv  = modelPDiv;
         modelPend = 0;
      end
      p = periodOf(modelDiv);
      if (doApply) begin
         expTx  = 0;
         expRx  = 0;
         nextTx = edgeNum + p;
         nextRx = edgeNum + p;
      end else begin
         expTx = (edgeNum == nextTx);
         if (expTx) nextTx += p;
         if (sync) begin
            expRx  = 0;
            nextRx = edgeNum + p / 2;
         end else begin
            expRx = (edgeNum == nextRx);
            if (expRx) nextRx += p;
         end
      end
   endtask

   task automatic applyStimulus(input bit rst, input bit wr, input logic [1:0] dv,
                                input bit txb, input bit rxb, input bit sync);
      @(negedge clock);
      reset       = rst;
      bus.cfg_wr  = wr;
      bus.cfg_div = dv;
      bus.tx_busy = txb;
      bus.rx_busy = rxb;
      bus.rx_sync = sync;
      @(posedge clock);
      edgeNum++;
      modelStep(rst, wr, int'(dv), txb, rxb, sync);
      #1;
      checkOutput("tx_tick",     int'(bus.tx_tick),     int'(expTx));
      checkOutput("rx_tick",     int'(bus.rx_tick),     int'(expRx));
      checkOutput("div_active",  int'(bus.div_active),  modelDiv);
      checkOutput("cfg_pending", int'(bus.cfg_pending), int'(modelPend));
   endtask

   task automatic idleCycles(input int n, input bit txb, input bit rxb);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 2'd0, txb, rxb, 0);
   endtask

   initial begin
      reset       = 1'b1;
      bus.cfg_wr  = 1'b0;
      bus.cfg_div = 2'd0;
      bus.tx_busy = 1'b0;
      bus.rx_busy = 1'b0;
      bus.rx_sync = 1'b0;

      for (int i = 0; i < 3; i++) applyStimulus(1, 0, 2'd0, 0, 0, 0);
      idleCycles(14, 0, 0);

      applyStimulus(0, 1, 2'd3, 0, 0, 0);
      idleCycles(60, 0, 0);

      applyStimulus(0, 0, 2'd0, 1, 0, 0);
      applyStimulus(0, 1, 2'd1, 1, 0, 0);
      idleCycles(12, 1, 0);
      idleCycles(30, 0, 0);

      applyStimulus(0, 1, 2'd2, 0, 0, 0);
      idleCycles(5, 0, 0);
      applyStimulus(0, 0, 2'd0, 0, 0, 1);
      idleCycles(40, 0, 0);

      // Drive rx_sync exactly on the edge where an RX tick would otherwise land.
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 40; i++) begin
            if (nextRx == edgeNum + 1) begin
               applyStimulus(0, 0, 2'd0, 0, 0, 1);
               break;
            end
            applyStimulus(0, 0, 2'd0, 0, 0, 0);
         end
         idleCycles(3, 0, 0);
      end
      idleCycles(20, 0, 0);

      applyStimulus(0, 1, 2'd1, 0, 0, 0);
      applyStimulus(0, 1, 2'd2, 0, 0, 0);
      idleCycles(30, 0, 0);

      applyStimulus(0, 1, 2'd3, 0, 1, 0);
      idleCycles(3, 0, 1);
      applyStimulus(1, 0, 2'd0, 0, 1, 0);
      idleCycles(10, 0, 0);

      for (int i = 0; i < 4000; i++) begin
         bit             rst;
         bit             wr;
         bit             sync;
         logic [1:0]     dv;
         if ($urandom_range(0, 7) == 0) txBusyState = ~txBusyState;
         if ($urandom_range(0, 7) == 0) rxBusyState = ~rxBusyState;
         rst  = ($urandom_range(0, 599) == 0);
         wr   = ($urandom_range(0, 39) == 0);
         sync = ($urandom_range(0, 14) == 0);
         dv   = 2'($urandom_range(0, 3));
         applyStimulus(rst, wr, dv, txBusyState, rxBusyState, sync);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
